stopwatch_ctrl: RTL and testbench

- MM:SS stopwatch controller that sequences a chain of four BCD digit counters: seconds ones, seconds tens, minutes ones, minutes tens.
- A start/stop/lap/clear FSM gates a clock prescaler that produces a one-second advance tick.
- A lap latch can freeze the display while counting continues.
- Sits between the debounced button logic and the 7-segment display driver.

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/stopwatch_ctrl_if.sv | 26 ++
 rtl/bcd_digit_cnt.sv | 41 ++++
 rtl/stopwatch_ctrl.sv | 141 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the MM:SS stopwatch: FSM encodings, BCD digit
// width and per-digit rollover limits.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] MIN_ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = 4'd5;

    // Rollover limit of digit idx in the chain, least significant first.
    function automatic logic [DIGIT_W-1:0] digit_max(input int idx);
        case (idx)
            0:       return SEC_ONES_MAX;
            1:       return SEC_TENS_MAX;
            2:       return MIN_ONES_MAX;
            default: return MIN_TENS_MAX;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button-pulse inputs and display-side outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic                     start_stop;
    logic                     lap;
    logic                     clear;
    logic [4*DIGIT_W-1:0]     disp;
    logic                     running;
    logic                     lap_active;
    logic                     wrap;
    logic [1:0]               state;

    // Side that issues button pulses and watches the display.
    modport master (
        output start_stop, lap, clear,
        input  disp, running, lap_active, wrap, state
    );

    // The stopwatch controller itself.
    modport slave (
        input  start_stop, lap, clear,
        output disp, running, lap_active, wrap, state
    );

endinterface

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the time chain: counts 0..MAX, carries out when it
// advances past MAX. A synchronous clear beats an increment.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] value,
    output logic               carry
);

    logic [DIGIT_W-1:0] value_reg;
    logic [DIGIT_W-1:0] value_next;

    assign carry = inc && (value_reg == MAX);
    assign value = value_reg;

    // Next digit value: clear, wrap at MAX, or plain increment.
    always_comb begin
        value_next = value_reg;
        if (clr) begin
            value_next = '0;
        end else if (inc) begin
            value_next = (value_reg == MAX) ? '0 : value_reg + DIGIT_W'(1);
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: start/stop/lap/clear FSM gating a one-second prescaler
// that advances a four-digit BCD chain, with a lap latch to freeze the
// display while counting continues.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_ctrl_if.slave  bus
);

    localparam int                CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  PRESC_LAST = CNT_W'(TICK_DIV - 1);
    localparam int                N_DIGITS   = 4;

    sw_state_t              state_reg;
    sw_state_t              state_next;
    logic                   capture_lap;

    logic [CNT_W-1:0]       presc_reg;
    logic [CNT_W-1:0]       presc_next;
    logic                   run_en;
    logic                   tick;

    logic [DIGIT_W-1:0]     digit [N_DIGITS];
    logic [N_DIGITS:0]      inc_chain;
    logic [4*DIGIT_W-1:0]   live_disp;
    logic [4*DIGIT_W-1:0]   lap_reg;
    logic                   wrap_reg;

    // Next state with clear > start_stop > lap priority; also flags lap capture.
    always_comb begin
        state_next  = state_reg;
        capture_lap = 1'b0;
        if (bus.clear) begin
            state_next = IDLE;
        end else if (bus.start_stop) begin
            case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                LAP:     state_next = PAUSE;
                default: state_next = IDLE;
            endcase
        end else if (bus.lap) begin
            case (state_reg)
                IDLE:    state_next = IDLE;
                RUN: begin
                    state_next  = LAP;
                    capture_lap = 1'b1;
                end
                PAUSE:   state_next = PAUSE;
                LAP:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Prescaler counts only from the registered running states; a clear on
    // the same edge suppresses the advance so the digits land on zero.
    assign run_en = (state_reg == RUN) || (state_reg == LAP);
    assign tick   = run_en && (presc_reg == PRESC_LAST) && !bus.clear;

    // Prescaler next value: zero in IDLE/clear, hold in PAUSE, wrap at the end.
    always_comb begin
        presc_next = presc_reg;
        if (bus.clear || (state_reg == IDLE)) begin
            presc_next = '0;
        end else if (run_en) begin
            presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + CNT_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    // Digit chain: each digit's carry is the next digit's increment, so a
    // full 59:59 rollover resolves combinationally within one edge.
    assign inc_chain[0] = tick;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            bcd_digit_cnt #(
                .MAX (digit_max(gi))
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (bus.clear),
                .inc   (inc_chain[gi]),
                .value (digit[gi]),
                .carry (inc_chain[gi+1])
            );
        end
    endgenerate

    assign live_disp = {digit[3], digit[2], digit[1], digit[0]};

    // Lap latch: snapshot of the live digits on LAP entry, zeroed by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_reg <= '0;
        end else if (bus.clear) begin
            lap_reg <= '0;
        end else if (capture_lap) begin
            lap_reg <= live_disp;
        end
    end

    // One-cycle pulse after the carry out of the top digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= inc_chain[N_DIGITS];
        end
    end

    assign bus.disp       = (state_reg == LAP) ? lap_reg : live_disp;
    assign bus.running    = run_en;
    assign bus.lap_active = (state_reg == LAP);
    assign bus.wrap       = wrap_reg;
    assign bus.state      = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a seconds-based behavioural model pushes the
// expected output vector each clock edge; it is popped and compared on the
// following falling edge, alongside directed checks of the key scenarios.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int RUN_LIMIT = 20000;

    logic clk;
    logic rst_n;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: whole seconds instead of digits.
    int m_state = 0;
    int m_presc = 0;
    int m_secs  = 0;
    int m_lap   = 0;
    bit m_wrap  = 1'b0;

    logic [20:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int q;
        m = s / 60;
        q = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(q / 10), 4'(q % 10)};
    endfunction

    function automatic logic [20:0] model_vec();
        logic [15:0] d;
        d = (m_state == 3) ? to_bcd(m_lap) : to_bcd(m_secs);
        return {2'(m_state), m_wrap, (m_state == 3), (m_state == 1 || m_state == 3), d};
    endfunction

    function automatic logic [20:0] obs_vec();
        return {sw_if.state, sw_if.wrap, sw_if.lap_active, sw_if.running, sw_if.disp};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_presc = 0;
        m_secs  = 0;
        m_lap   = 0;
        m_wrap  = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic l, input logic c);
        int  st;
        int  old_secs;
        bit  run_old;
        bit  tk;
        st       = m_state;
        old_secs = m_secs;
        run_old  = (st == 1) || (st == 3);
        tk       = !c && run_old && (m_presc == TICK_DIV - 1);
        m_wrap   = tk && (m_secs == 3599);
        if (c) begin
            m_state = 0;
            m_presc = 0;
            m_secs  = 0;
            m_lap   = 0;
        end else begin
            if (st == 0)      m_presc = 0;
            else if (run_old) m_presc = tk ? 0 : m_presc + 1;
            if (tk) m_secs = (m_secs + 1) % 3600;
            if (s) begin
                case (st)
                    0:       m_state = 1;
                    1:       m_state = 2;
                    2:       m_state = 1;
                    default: m_state = 2;
                endcase
            end else if (l) begin
                if (st == 1) begin
                    m_state = 3;
                    m_lap   = old_secs;
                end else if (st == 3) begin
                    m_state = 1;
                end
            end
        end
    endtask

    // One clock: drive pulses, model the edge, compare on the falling edge.
    task automatic step(input logic s, input logic l, input logic c);
        logic [20:0] exp_v;
        sw_if.start_stop = s;
        sw_if.lap        = l;
        sw_if.clear      = c;
        @(posedge clk);
        model_edge(s, l, c);
        exp_q.push_back(model_vec());
        @(negedge clk);
        exp_v = exp_q.pop_front();
        check("cycle", 32'(obs_vec()), 32'(exp_v));
        sw_if.start_stop = 1'b0;
        sw_if.lap        = 1'b0;
        sw_if.clear      = 1'b0;
    endtask

    // Step until the next edge will advance the count to target+1.
    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (!(m_secs == target && m_presc == TICK_DIV - 1) && guard < RUN_LIMIT) begin
            step(1'b0, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= RUN_LIMIT) check("run_until_timeout", 32'(guard), 32'(0));
    endtask

    initial begin
        rst_n            = 1'b0;
        sw_if.start_stop = 1'b0;
        sw_if.lap        = 1'b0;
        sw_if.clear      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_disp",    32'(sw_if.disp),    32'h0);
        check("rst_running", 32'(sw_if.running), 32'h0);
        check("rst_state",   32'(sw_if.state),   32'h0);
        check("rst_wrap",    32'(sw_if.wrap),    32'h0);
        rst_n = 1'b1;

        // Idle, then start and watch first two advances.
        repeat (20) step(1'b0, 1'b0, 1'b0);
        check("idle_disp",  32'(sw_if.disp),  32'h0);
        check("idle_state", 32'(sw_if.state), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        check("start_state", 32'(sw_if.state), 32'h1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("pre_first_tick", 32'(sw_if.disp), 32'h0000);
        step(1'b0, 1'b0, 1'b0);
        check("first_tick", 32'(sw_if.disp), 32'h0001);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        check("second_tick", 32'(sw_if.disp), 32'h0002);

        // Carries into minutes and tens of minutes, then full rollover.
        run_until(59);
        check("at_0059", 32'(sw_if.disp), 32'h0059);
        step(1'b0, 1'b0, 1'b0);
        check("carry_0100", 32'(sw_if.disp), 32'h0100);
        run_until(599);
        step(1'b0, 1'b0, 1'b0);
        check("carry_1000", 32'(sw_if.disp), 32'h1000);
        run_until(3599);
        check("at_5959", 32'(sw_if.disp), 32'h5959);
        step(1'b0, 1'b0, 1'b0);
        check("wrap_disp",    32'(sw_if.disp),    32'h0000);
        check("wrap_pulse",   32'(sw_if.wrap),    32'h1);
        check("wrap_running", 32'(sw_if.running), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check("wrap_one_cycle", 32'(sw_if.wrap), 32'h0);

        // Pause keeps the partial second.
        step(1'b0, 1'b0, 1'b1);
        check("clear_state", 32'(sw_if.state), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        run_until(6);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (50) step(1'b0, 1'b0, 1'b0);
        check("pause_disp",  32'(sw_if.disp),  32'h0007);
        check("pause_state", 32'(sw_if.state), 32'h2);
        step(1'b1, 1'b0, 1'b0);
        check("resume_edge", 32'(sw_if.disp), 32'h0007);
        step(1'b0, 1'b0, 1'b0);
        check("resume_partial", 32'(sw_if.disp), 32'h0008);

        // Lap freeze while counting continues underneath.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        run_until(2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("lap_active", 32'(sw_if.lap_active), 32'h1);
        repeat (12) step(1'b0, 1'b0, 1'b0);
        check("lap_frozen", 32'(sw_if.disp), 32'h0003);
        step(1'b0, 1'b1, 1'b0);
        check("lap_exit_live", 32'(sw_if.disp),       32'h0006);
        check("lap_exit_flag", 32'(sw_if.lap_active), 32'h0);

        // Clear wins over simultaneous start_stop and lap.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        run_until(4);
        step(1'b0, 1'b0, 1'b0);
        check("at_0005", 32'(sw_if.disp), 32'h0005);
        step(1'b1, 1'b1, 1'b1);
        check("prio_state",   32'(sw_if.state),   32'h0);
        check("prio_disp",    32'(sw_if.disp),    32'h0);
        check("prio_running", 32'(sw_if.running), 32'h0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        check("prio_no_run", 32'(sw_if.disp), 32'h0);

        // Asynchronous reset mid-count while in LAP.
        step(1'b1, 1'b0, 1'b0);
        run_until(2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_disp",    32'(sw_if.disp),       32'h0);
        check("arst_running", 32'(sw_if.running),    32'h0);
        check("arst_lap",     32'(sw_if.lap_active), 32'h0);
        check("arst_state",   32'(sw_if.state),      32'h0);
        check("arst_wrap",    32'(sw_if.wrap),       32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        check("post_rst_tick", 32'(sw_if.disp), 32'h0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
